// File: rtl/popcnt_acc_pkg.sv
// popcnt_acc_pkg: shared state type, count-width helper and default sizes for the popcount accumulator
package popcnt_acc_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} acc_state_t;
  localparam int DEF_LANES  = 4;
  localparam int DEF_LANE_W = 8;
  localparam int DEF_ACC_W  = 12;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/popcnt_acc_pipe_lane_popcnt.sv
// lane_popcnt: combinational population count of one lane, full-adder (3:2) leaves summed into a count
module lane_popcnt import popcnt_acc_pkg::*; #(
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [LANE_W-1:0]        bits,
  output logic [cnt_w(LANE_W)-1:0] cnt
);
  localparam int G  = (LANE_W + 2) / 3;
  localparam int CW = cnt_w(LANE_W);
  logic [3*G-1:0] pad;
  logic [G-1:0]   fs, fc;
  assign pad = (3*G)'(bits);
  for (genvar i = 0; i < G; i++) begin : g_fa
    assign fs[i] = pad[3*i] ^ pad[3*i+1] ^ pad[3*i+2];
    assign fc[i] = (pad[3*i] & pad[3*i+1]) | (pad[3*i+2] & (pad[3*i] ^ pad[3*i+1]));
  end
  always_comb begin
    cnt = '0;
    for (int i = 0; i < G; i++) cnt = cnt + CW'({fc[i], fs[i]});
  end
endmodule

// File: rtl/popcnt_acc_pipe.sv
// popcnt_acc_pipe: three-stage popcount/XNOR-popcount pipeline with saturating per-frame accumulation
module popcnt_acc_pipe import popcnt_acc_pkg::*; #(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [LANES*LANE_W-1:0] in_wgt,
  input  logic                    in_xnor,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_sum,
  output logic                    out_ovf
);
  localparam int W  = LANES * LANE_W;
  localparam int CW = cnt_w(LANE_W);
  localparam int SW = cnt_w(W);
  logic                      en;
  logic                      s1_v, s1_xnor, s1_last;
  logic [W-1:0]              s1_data, s1_wgt, s1_bits;
  logic [LANES-1:0][CW-1:0]  lane_cnt, s2_cnt;
  logic                      s2_v, s2_last;
  logic [SW-1:0]             lane_sum, s3_sum;
  logic                      s3_v, s3_last;
  acc_state_t                state, state_next;
  logic [ACC_W-1:0]          acc, acc_base, acc_next;
  logic                      ovf, ovf_base, ovf_next;
  logic [ACC_W:0]            sum_ext;
  // A held result freezes the whole pipe, so nothing in flight can be lost.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign s1_bits  = s1_xnor ? ~(s1_data ^ s1_wgt) : s1_data;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_popcnt #(.LANE_W(LANE_W)) u_cnt (
      .bits(s1_bits[i*LANE_W +: LANE_W]),
      .cnt (lane_cnt[i])
    );
  end
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + SW'(s2_cnt[i]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_xnor <= 1'b0;
      s1_last <= 1'b0;
      s1_data <= '0;
      s1_wgt  <= '0;
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      s2_cnt  <= '0;
      s3_v    <= 1'b0;
      s3_last <= 1'b0;
      s3_sum  <= '0;
    end else if (en) begin
      s1_v    <= in_valid;
      s1_xnor <= in_xnor;
      s1_last <= in_last;
      s1_data <= in_data;
      s1_wgt  <= in_wgt;
      s2_v    <= s1_v;
      s2_last <= s1_last;
      s2_cnt  <= lane_cnt;
      s3_v    <= s2_v;
      s3_last <= s2_last;
      s3_sum  <= lane_sum;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  always_comb state_next = (en && s3_v) ? (s3_last ? IDLE : RUN) : state;
  // IDLE means the S3 beat opens a frame: start from zero and drop the old overflow.
  always_comb begin
    acc_base = (state == RUN) ? acc : '0;
    ovf_base = (state == RUN) && ovf;
    sum_ext  = {1'b0, acc_base} + (ACC_W+1)'(s3_sum);
    acc_next = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    ovf_next = ovf_base | sum_ext[ACC_W];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      if (s3_v) begin
        acc <= acc_next;
        ovf <= ovf_next;
      end
      if (s3_v && s3_last) begin
        out_valid <= 1'b1;
        out_sum   <= acc_next;
        out_ovf   <= ovf_next;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: doc/popcnt_acc_pipe.md
POPCNT_ACC_PIPE -- requirements
Module: popcnt_acc_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 4, meaning number of input lanes per beat.
REQ-002 The block SHALL have parameter LANE_W, default 8, meaning bits per lane, legal range 2..64.
REQ-003 The block SHALL have parameter ACC_W, default 12, meaning frame accumulator and result width, at least clog2(LANES*LANE_W+1).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  beat present.
REQ-007 in_ready  output  1  beat accepted when in_valid && in_ready at a rising edge.
REQ-008 in_data  input  LANES*LANE_W  activation bits; lane i = bits [i*LANE_W +: LANE_W].
REQ-009 in_wgt  input  LANES*LANE_W  weight bits, used only in XNOR mode.
REQ-010 in_xnor  input  1  per-beat mode: 0 = count ones of in_data, 1 = count ones of ~(in_data ^ in_wgt).
REQ-011 in_last  input  1  final beat of a frame.
REQ-012 out_valid  output  1  frame result present.
REQ-013 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-014 out_sum  output  ACC_W  frame bit count, saturated.
REQ-015 out_ovf  output  1  frame saturated.

Function
REQ-016 Pipeline SHALL have three register stages: S1 input capture, S2 per-lane counts (each clog2(LANE_W+1) bits), S3 lane sum plus frame accumulation.
REQ-017 Global advance enable SHALL be en = !(out_valid && !out_ready); all stages hold when en = 0.
REQ-018 in_ready SHALL equal en, combinationally; no beat is dropped or duplicated under backpressure.
REQ-019 A frame whose last beat is accepted at edge k SHALL present out_valid = 1 after edge k+3, when no stall occurs; each stall cycle adds one cycle.
REQ-020 Accumulator FSM SHALL have states IDLE (no open frame) and RUN (frame open); S3 beat in IDLE loads acc with beat sum, in RUN adds beat sum; beat with last returns to IDLE; beat without last goes/stays RUN.
REQ-021 Single-beat frame (in_last on first beat) SHALL be legal; result = that beat's count.
REQ-022 Addition SHALL saturate at 2^ACC_W-1; saturation sets a sticky frame overflow flag, cleared on the first beat of the next frame.
REQ-023 On S3 last beat, out_sum and out_ovf SHALL be loaded and out_valid set; out_sum/out_ovf SHALL stay stable while out_valid && !out_ready.
REQ-024 Result handshake completing in the same cycle a new last beat reaches S3 SHALL load the new result with out_valid remaining 1.
REQ-025 Handshake completing with no new result SHALL clear out_valid at that edge.
REQ-026 in_xnor SHALL be honoured per beat; frames may mix modes.
REQ-027 Bubbles (in_valid = 0) mid-frame SHALL not alter accumulation.

Reset
REQ-028 rst_n low SHALL asynchronously clear all pipeline valids, acc, FSM to IDLE, out_valid = 0, out_sum = 0, out_ovf = 0; in_ready = 1 during and after reset.
REQ-029 Reset mid-frame SHALL discard the open frame and all in-flight beats; first beat after release starts a new frame.

Structure
REQ-030 Package popcnt_acc_pkg SHALL hold the FSM state type, a clog2-based count-width function and default parameter constants.
REQ-031 Sub-module lane_popcnt (combinational, parameter LANE_W, 3:2/4:2 compressor tree) SHALL be instantiated LANES times between S1 and S2.
REQ-032 Lane-sum adder tree SHALL be combinational between S2 and S3; no other sub-modules.

Verification (defaults unless stated)
REQ-033 One beat in_data = 32'hFFFF_0000, in_xnor = 0, in_last = 1 -> out_valid after 3 edges, out_sum = 16, out_ovf = 0.
REQ-034 Three beats 32'hFFFF_FFFF, 32'h0000_0001, in_xnor = 1 with in_data = in_wgt = 32'hA5A5_A5A5, last on third -> out_sum = 65.
REQ-035 ACC_W = 8, eight beats of 32'hFFFF_FFFF -> out_sum = 255, out_ovf = 1; next one-beat frame 32'h0000_000F -> out_sum = 4, out_ovf = 0.
REQ-036 Back-to-back one-beat frames with out_ready held 0 for 5 cycles -> in_ready = 0 while stalled, out_sum stable, all results delivered in order, none lost.
REQ-037 rst_n pulsed low after 2 beats of an open frame -> outputs zero immediately; next frame 32'h0000_0003 last -> out_sum = 2.
REQ-038 Random beats, bubbles and out_ready toggling vs. reference model -> exact out_sum/out_ovf sequence match.
